// File: rtl/led_display_pkg.sv
// Shared definitions for the LED display peripheral: register offsets, control bit
// positions, AXI response codes, channel FSM states and the hex-to-segment decoder.
package led_display_pkg;

  localparam logic [7:0] OFF_CTRL     = 8'h00;
  localparam logic [7:0] OFF_STATUS   = 8'h04;
  localparam logic [7:0] OFF_DUTY     = 8'h08;
  localparam logic [7:0] OFF_SCAN_DIV = 8'h0C;
  localparam logic [7:0] OFF_DIGIT0   = 8'h10;

  localparam int CTRL_ENABLE = 0;
  localparam int CTRL_HEX    = 1;

  typedef enum logic [1:0] {
    RESP_OKAY   = 2'b00,
    RESP_SLVERR = 2'b10
  } resp_t;

  typedef enum logic {W_IDLE, W_RESP} wr_state_t;
  typedef enum logic {R_IDLE, R_DATA} rd_state_t;

  // Segment order {g,f,e,d,c,b,a}, active-high.
  function automatic logic [6:0] hex7seg(input logic [3:0] v);
    case (v)
      4'h0: return 7'h3F;
      4'h1: return 7'h06;
      4'h2: return 7'h5B;
      4'h3: return 7'h4F;
      4'h4: return 7'h66;
      4'h5: return 7'h6D;
      4'h6: return 7'h7D;
      4'h7: return 7'h07;
      4'h8: return 7'h7F;
      4'h9: return 7'h6F;
      4'hA: return 7'h77;
      4'hB: return 7'h7C;
      4'hC: return 7'h39;
      4'hD: return 7'h5E;
      4'hE: return 7'h79;
      default: return 7'h71;
    endcase
  endfunction

endpackage

// File: rtl/led_display_axil_mux_scan.sv
// Digit scanner for the LED display: prescaler, digit index, 8-bit PWM and the
// registered segment/anode outputs. Blink masking is built only with LED_DISPLAY_BLINK_EN.
module led_scan_pwm
  import led_display_pkg::*;
#(
  parameter int NUM_DIGITS = 8
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic                       enable,
  input  logic                       hex_mode,
  input  logic [7:0]                 duty,
  input  logic [15:0]                scan_div,
  input  logic                       restart,
  input  logic [NUM_DIGITS-1:0][7:0] digits,
`ifdef LED_DISPLAY_BLINK_EN
  input  logic [15:0]                blink_mask,
`endif
  output logic [3:0]                 index,
  output logic [7:0]                 seg_n,
  output logic [NUM_DIGITS-1:0]      an_n
);

  logic [15:0]           presc;
  logic [3:0]            idx;
  logic [7:0]            pwm_cnt;
  logic [7:0]            cur_digit;
  logic [7:0]            seg_p0;
  logic [NUM_DIGITS-1:0] an_p0;
  logic                  vld_p0;
  logic                  blink_dark;

  always_comb begin
    cur_digit = '0;
    an_p0     = '0;
    for (int k = 0; k < NUM_DIGITS; k++) begin
      if (idx == 4'(k)) begin
        cur_digit = digits[k];
        an_p0[k]  = 1'b1;
      end
    end
  end

`ifdef LED_DISPLAY_BLINK_EN
  logic [23:0] blink_tmr;

  always_ff @(posedge clk) begin
    if (rst) blink_tmr <= '0;
    else     blink_tmr <= blink_tmr + 24'd1;
  end

  // Bit 23 flips every 2^23 cycles and serves as the blink phase.
  assign blink_dark = blink_tmr[23] && blink_mask[idx];
`else
  assign blink_dark = 1'b0;
`endif

  assign vld_p0 = enable && (pwm_cnt < duty) && !blink_dark;
  assign seg_p0 = hex_mode ? {cur_digit[7], hex7seg(cur_digit[3:0])} : cur_digit;

  // Stage p0 -> output register: scan state is turned into pins one cycle later.
  always_ff @(posedge clk) begin
    if (rst) begin
      presc   <= '0;
      idx     <= '0;
      pwm_cnt <= '0;
      seg_n   <= 8'hFF;
      an_n    <= '1;
    end else begin
      pwm_cnt <= pwm_cnt + 8'd1;
      if (restart) begin
        presc <= '0;
      end else if (presc == scan_div) begin
        presc <= '0;
        idx   <= (idx == 4'(NUM_DIGITS - 1)) ? 4'd0 : idx + 4'd1;
      end else begin
        presc <= presc + 16'd1;
      end
      seg_n <= vld_p0 ? ~seg_p0 : 8'hFF;
      an_n  <= vld_p0 ? ~an_p0 : '1;
    end
  end

  assign index = idx;

endmodule

// File: rtl/led_display_axil_mux.sv
// AXI4-Lite register front end for the multiplexed 7-segment display.
// Optional build macro LED_DISPLAY_BLINK_EN adds a blink mask in SCAN_DIV[31:16].
module led_display_axil_mux
  import led_display_pkg::*;
#(
  parameter int          NUM_DIGITS         = 8,
  parameter int          C_S_AXI_ADDR_WIDTH = 7,
  parameter int          C_S_AXI_DATA_WIDTH = 32,
  parameter logic [15:0] SCAN_DIV_RST       = 16'd50000
) (
  input  logic                            ACLK,
  input  logic                            ARESET,
  input  logic [C_S_AXI_ADDR_WIDTH-1:0]   S_AXI_AWADDR,
  input  logic [2:0]                      S_AXI_AWPROT,
  input  logic                            S_AXI_AWVALID,
  output logic                            S_AXI_AWREADY,
  input  logic [C_S_AXI_DATA_WIDTH-1:0]   S_AXI_WDATA,
  input  logic [C_S_AXI_DATA_WIDTH/8-1:0] S_AXI_WSTRB,
  input  logic                            S_AXI_WVALID,
  output logic                            S_AXI_WREADY,
  output logic [1:0]                      S_AXI_BRESP,
  output logic                            S_AXI_BVALID,
  input  logic                            S_AXI_BREADY,
  input  logic [C_S_AXI_ADDR_WIDTH-1:0]   S_AXI_ARADDR,
  input  logic [2:0]                      S_AXI_ARPROT,
  input  logic                            S_AXI_ARVALID,
  output logic                            S_AXI_ARREADY,
  output logic [C_S_AXI_DATA_WIDTH-1:0]   S_AXI_RDATA,
  output logic [1:0]                      S_AXI_RRESP,
  output logic                            S_AXI_RVALID,
  input  logic                            S_AXI_RREADY,
  output logic [7:0]                      seg_n,
  output logic [NUM_DIGITS-1:0]           an_n
);

  localparam int WORD_W = C_S_AXI_ADDR_WIDTH - 2;

  wr_state_t wr_state, wr_next;
  rd_state_t rd_state, rd_next;
  logic      wr_fire, rd_fire, wr_ok, rd_ok, scan_restart;
  logic [WORD_W-1:0] wr_word, rd_word;
  logic [31:0] rd_val;

  logic [1:0]                 ctrl;
  logic [7:0]                 duty;
  logic [15:0]                scan_div;
  logic [15:0]                blink_hi;
  logic [NUM_DIGITS-1:0][7:0] digits;
  logic [3:0]                 scan_index;
  resp_t                      bresp_q, rresp_q;
  logic [31:0]                rdata_q;
  logic                       unused_ok;

  assign wr_word = S_AXI_AWADDR[C_S_AXI_ADDR_WIDTH-1:2];
  assign rd_word = S_AXI_ARADDR[C_S_AXI_ADDR_WIDTH-1:2];
  assign unused_ok = ^{S_AXI_AWPROT, S_AXI_ARPROT, S_AXI_AWADDR[1:0], S_AXI_ARADDR[1:0],
                       S_AXI_WDATA, S_AXI_WSTRB};

  // Handshakes only happen from idle; AW and W are accepted strictly together.
  always_comb begin
    wr_next = wr_state;
    wr_fire = 1'b0;
    case (wr_state)
      W_IDLE: if (S_AXI_AWVALID && S_AXI_WVALID) begin
        wr_fire = 1'b1;
        wr_next = W_RESP;
      end
      W_RESP: if (S_AXI_BREADY) wr_next = W_IDLE;
    endcase
  end

  always_comb begin
    rd_next = rd_state;
    rd_fire = 1'b0;
    case (rd_state)
      R_IDLE: if (S_AXI_ARVALID) begin
        rd_fire = 1'b1;
        rd_next = R_DATA;
      end
      R_DATA: if (S_AXI_RREADY) rd_next = R_IDLE;
    endcase
  end

  assign S_AXI_AWREADY = wr_fire;
  assign S_AXI_WREADY  = wr_fire;
  assign S_AXI_BVALID  = (wr_state == W_RESP);
  assign S_AXI_BRESP   = bresp_q;
  assign S_AXI_ARREADY = rd_fire;
  assign S_AXI_RVALID  = (rd_state == R_DATA);
  assign S_AXI_RRESP   = rresp_q;
  assign S_AXI_RDATA   = rdata_q;

`ifdef LED_DISPLAY_BLINK_EN
  logic [15:0] blink_mask;
  assign blink_hi = blink_mask;
`else
  assign blink_hi = 16'h0000;
`endif

  // STATUS is readable but not writable, so it is absent from the write decode.
  always_comb begin
    wr_ok = (wr_word == WORD_W'(OFF_CTRL[7:2])) || (wr_word == WORD_W'(OFF_DUTY[7:2])) ||
            (wr_word == WORD_W'(OFF_SCAN_DIV[7:2]));
    for (int k = 0; k < NUM_DIGITS; k++)
      if (wr_word == WORD_W'(int'(OFF_DIGIT0[7:2]) + k)) wr_ok = 1'b1;
  end

  always_comb begin
    rd_val = '0;
    rd_ok  = 1'b0;
    if (rd_word == WORD_W'(OFF_CTRL[7:2]))     begin rd_val = {30'b0, ctrl};       rd_ok = 1'b1; end
    if (rd_word == WORD_W'(OFF_STATUS[7:2]))   begin rd_val = {28'b0, scan_index}; rd_ok = 1'b1; end
    if (rd_word == WORD_W'(OFF_DUTY[7:2]))     begin rd_val = {24'b0, duty};       rd_ok = 1'b1; end
    if (rd_word == WORD_W'(OFF_SCAN_DIV[7:2])) begin rd_val = {blink_hi, scan_div}; rd_ok = 1'b1; end
    for (int k = 0; k < NUM_DIGITS; k++) begin
      if (rd_word == WORD_W'(int'(OFF_DIGIT0[7:2]) + k)) begin
        rd_val = {24'b0, digits[k]};
        rd_ok  = 1'b1;
      end
    end
  end

  assign scan_restart = wr_fire && (wr_word == WORD_W'(OFF_SCAN_DIV[7:2]));

  always_ff @(posedge ACLK) begin
    if (ARESET) begin
      wr_state <= W_IDLE;
      rd_state <= R_IDLE;
    end else begin
      wr_state <= wr_next;
      rd_state <= rd_next;
    end
  end

  // Register file and response registers; reads sample pre-write contents.
  always_ff @(posedge ACLK) begin
    if (ARESET) begin
      ctrl     <= '0;
      duty     <= 8'hFF;
      scan_div <= SCAN_DIV_RST;
      digits   <= '0;
`ifdef LED_DISPLAY_BLINK_EN
      blink_mask <= '0;
`endif
      bresp_q  <= RESP_OKAY;
      rresp_q  <= RESP_OKAY;
      rdata_q  <= '0;
    end else begin
      if (wr_fire) begin
        bresp_q <= wr_ok ? RESP_OKAY : RESP_SLVERR;
        if (S_AXI_WSTRB[0]) begin
          if (wr_word == WORD_W'(OFF_CTRL[7:2]))     ctrl          <= S_AXI_WDATA[1:0];
          if (wr_word == WORD_W'(OFF_DUTY[7:2]))     duty          <= S_AXI_WDATA[7:0];
          if (wr_word == WORD_W'(OFF_SCAN_DIV[7:2])) scan_div[7:0] <= S_AXI_WDATA[7:0];
          for (int k = 0; k < NUM_DIGITS; k++)
            if (wr_word == WORD_W'(int'(OFF_DIGIT0[7:2]) + k)) digits[k] <= S_AXI_WDATA[7:0];
        end
        if (S_AXI_WSTRB[1] && wr_word == WORD_W'(OFF_SCAN_DIV[7:2]))
          scan_div[15:8] <= S_AXI_WDATA[15:8];
`ifdef LED_DISPLAY_BLINK_EN
        if (S_AXI_WSTRB[2] && wr_word == WORD_W'(OFF_SCAN_DIV[7:2]))
          blink_mask[7:0] <= S_AXI_WDATA[23:16];
        if (S_AXI_WSTRB[3] && wr_word == WORD_W'(OFF_SCAN_DIV[7:2]))
          blink_mask[15:8] <= S_AXI_WDATA[31:24];
`endif
      end
      if (rd_fire) begin
        rresp_q <= rd_ok ? RESP_OKAY : RESP_SLVERR;
        rdata_q <= rd_val;
      end
    end
  end

  led_scan_pwm #(
    .NUM_DIGITS(NUM_DIGITS)
  ) u_scan (
    .clk       (ACLK),
    .rst       (ARESET),
    .enable    (ctrl[CTRL_ENABLE]),
    .hex_mode  (ctrl[CTRL_HEX]),
    .duty      (duty),
    .scan_div  (scan_div),
    .restart   (scan_restart),
    .digits    (digits),
`ifdef LED_DISPLAY_BLINK_EN
    .blink_mask(blink_mask),
`endif
    .index     (scan_index),
    .seg_n     (seg_n),
    .an_n      (an_n)
  );

endmodule
